// File: rtl/jpeg_dct_seq.sv
// Single-clock sequencer for the two-pass 8x8 DCT and quantiser.
// Row pass fills the transpose memory; column pass feeds the quantiser and output blockram.
module jpeg_dct_seq #(
  parameter int DCT_LAT   = 4,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 clr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovr_o,
  output logic [BLK_CNT_W-1:0] blk_cnt_o,
  output logic                 rd_en_o,
  output logic [8:0]           rd_addr_o,
  output logic                 reg1en_o,
  output logic                 mux1_o,
  output logic                 dct_stb_o,
  output logic                 twr_o,
  output logic                 trd_o,
  output logic [1:0]           mux2_o,
  output logic                 wren_o,
  output logic [4:0]           wrc_o,
  output logic [5:0]           rec_idx_o
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, COL, FLUSH} state_t;

  state_t             state_reg;
  logic [4:0]         cnt_reg;
  logic [3:0]         twr_cnt_reg;
  logic [DCT_LAT-1:0] row_pipe_reg;
  logic [DCT_LAT-1:0] col_pipe_reg;
  logic               burst_run_reg;
  logic [1:0]         burst_phase_reg;
  logic [4:0]         wrc_reg;
  logic               row_stb;
  logic               col_stb;
  logic               burst_head;
  logic               last_wr;

  assign row_stb    = dct_stb_o & ~mux1_o;
  assign col_stb    = dct_stb_o & mux1_o;
  assign burst_head = col_pipe_reg[DCT_LAT-1];
  assign twr_o      = row_pipe_reg[DCT_LAT-1];
  assign wren_o     = burst_head | burst_run_reg;
  assign mux2_o     = burst_phase_reg;
  assign wrc_o      = wrc_reg;
  assign rec_idx_o  = {wrc_reg, 1'b0};
  assign last_wr    = (state_reg == FLUSH) && wren_o && (wrc_reg == 5'd31);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      twr_cnt_reg <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      reg1en_o    <= 1'b0;
      mux1_o      <= 1'b0;
      dct_stb_o   <= 1'b0;
      trd_o       <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      reg1en_o  <= 1'b0;
      mux1_o    <= 1'b0;
      dct_stb_o <= 1'b0;
      trd_o     <= 1'b0;
      if (twr_o) twr_cnt_reg <= twr_cnt_reg + 4'd1;
      if (abort_i) begin
        state_reg   <= IDLE;
        busy_o      <= 1'b0;
        cnt_reg     <= '0;
        twr_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            busy_o <= 1'b0;
            // a start arriving in the done cycle belongs to the block just finished
            if (start_i && !done_o) begin
              state_reg   <= LOAD;
              busy_o      <= 1'b1;
              cnt_reg     <= '0;
              twr_cnt_reg <= '0;
              rd_en_o     <= 1'b1;
            end
          end
          LOAD: begin
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd15) begin
              state_reg <= DRAIN;
              dct_stb_o <= 1'b1;
            end else begin
              rd_en_o   <= 1'b1;
              rd_addr_o <= 9'(cnt_reg + 5'd1);
              reg1en_o  <= ~cnt_reg[0];
              dct_stb_o <= cnt_reg[0];
            end
          end
          DRAIN: begin
            if (twr_o && twr_cnt_reg == 4'd7) begin
              state_reg <= COL;
              cnt_reg   <= '0;
              trd_o     <= 1'b1;
              dct_stb_o <= 1'b1;
              mux1_o    <= 1'b1;
            end
          end
          COL: begin
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd28) begin
              state_reg <= FLUSH;
            end else if (cnt_reg[1:0] == 2'd3) begin
              trd_o     <= 1'b1;
              dct_stb_o <= 1'b1;
              mux1_o    <= 1'b1;
            end
          end
          FLUSH: begin
            if (last_wr) begin
              state_reg <= IDLE;
              done_o    <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Strobe delay lines model the DCT latency for each pass.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_pipe_reg <= '0;
      col_pipe_reg <= '0;
    end else if (abort_i) begin
      row_pipe_reg <= '0;
      col_pipe_reg <= '0;
    end else begin
      row_pipe_reg[0] <= row_stb;
      col_pipe_reg[0] <= col_stb;
      for (int i = 1; i < DCT_LAT; i++) begin
        row_pipe_reg[i] <= row_pipe_reg[i-1];
        col_pipe_reg[i] <= col_pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_run_reg   <= 1'b0;
      burst_phase_reg <= '0;
      wrc_reg         <= '0;
    end else if (abort_i) begin
      burst_run_reg   <= 1'b0;
      burst_phase_reg <= '0;
      wrc_reg         <= '0;
    end else begin
      if (wren_o) wrc_reg <= wrc_reg + 5'd1;
      if (burst_head) begin
        burst_run_reg   <= 1'b1;
        burst_phase_reg <= 2'd1;
      end else if (burst_run_reg && burst_phase_reg == 2'd3) begin
        burst_run_reg   <= 1'b0;
        burst_phase_reg <= 2'd0;
      end else if (burst_run_reg) begin
        burst_phase_reg <= burst_phase_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_o     <= 1'b0;
      blk_cnt_o <= '0;
    end else if (clr_i) begin
      ovr_o     <= 1'b0;
      blk_cnt_o <= '0;
    end else begin
      if (start_i && !abort_i && state_reg != IDLE) ovr_o <= 1'b1;
      if (!abort_i && last_wr) blk_cnt_o <= blk_cnt_o + BLK_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jpeg_dct_seq.sv
// Bench for jpeg_dct_seq: two instances (DCT_LAT 4 and 1) checked every cycle against a timeline model.
module tb_jpeg_dct_seq;
  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int W0   = 16;
  localparam int W1   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] abort_v = '0;
  logic [1:0] clr_v = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic       reg1en;
    logic       mux1;
    logic       stb;
    logic       twr;
    logic       trd;
    logic [1:0] mux2;
    logic       wren;
    logic [4:0] wrc;
    logic [5:0] rec;
  } obs_t;

  logic          busy0, done0, ovr0, rd_en0, reg1en0, mux1_0, stb0, twr0, trd0, wren0;
  logic [W0-1:0] blk0;
  logic [8:0]    addr0;
  logic [1:0]    mux2_0;
  logic [4:0]    wrc0;
  logic [5:0]    rec0;
  logic          busy1, done1, ovr1, rd_en1, reg1en1, mux1_1, stb1, twr1, trd1, wren1;
  logic [W1-1:0] blk1;
  logic [8:0]    addr1;
  logic [1:0]    mux2_1;
  logic [4:0]    wrc1;
  logic [5:0]    rec1;

  jpeg_dct_seq #(.DCT_LAT(LAT0), .BLK_CNT_W(W0)) u4 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .abort_i(abort_v[0]), .clr_i(clr_v[0]),
    .busy_o(busy0), .done_o(done0), .ovr_o(ovr0), .blk_cnt_o(blk0),
    .rd_en_o(rd_en0), .rd_addr_o(addr0), .reg1en_o(reg1en0), .mux1_o(mux1_0),
    .dct_stb_o(stb0), .twr_o(twr0), .trd_o(trd0), .mux2_o(mux2_0),
    .wren_o(wren0), .wrc_o(wrc0), .rec_idx_o(rec0)
  );

  jpeg_dct_seq #(.DCT_LAT(LAT1), .BLK_CNT_W(W1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .abort_i(abort_v[1]), .clr_i(clr_v[1]),
    .busy_o(busy1), .done_o(done1), .ovr_o(ovr1), .blk_cnt_o(blk1),
    .rd_en_o(rd_en1), .rd_addr_o(addr1), .reg1en_o(reg1en1), .mux1_o(mux1_1),
    .dct_stb_o(stb1), .twr_o(twr1), .trd_o(trd1), .mux2_o(mux2_1),
    .wren_o(wren1), .wrc_o(wrc1), .rec_idx_o(rec1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit act_m [2];
  int s_m   [2];
  int blk_m [2];
  bit ovr_m [2];
  int t_m, d_m;
  obs_t exp0, exp1, got0, got1;

  // Expected outputs at offset t after the cycle in which start was accepted.
  function automatic obs_t expect_obs(input int lat, input bit a, input int t);
    obs_t o;
    int   w;
    o = '0;
    if (!a) return o;
    o.busy   = (t >= 1 && t <= 50 + 2*lat);
    o.done   = (t == 50 + 2*lat);
    if (t >= 1 && t <= 16) begin
      o.rd_en   = 1'b1;
      o.rd_addr = 9'(t - 1);
    end
    o.reg1en = (t >= 2 && t <= 16 && t % 2 == 0);
    o.twr    = (t >= 3 + lat && t <= 17 + lat && (t - 3 - lat) % 2 == 0);
    o.trd    = (t >= 18 + lat && t <= 46 + lat && (t - 18 - lat) % 4 == 0);
    o.mux1   = o.trd;
    o.stb    = o.trd || (t >= 3 && t <= 17 && t % 2 == 1);
    w = t - (18 + 2*lat);
    if (w >= 0 && w <= 31) begin
      o.wren = 1'b1;
      o.mux2 = 2'(w % 4);
      o.wrc  = 5'(w);
      o.rec  = 6'(2*w);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        act_m[m] = 1'b0;
        blk_m[m] = 0;
        ovr_m[m] = 1'b0;
      end else begin
        t_m = cyc - s_m[m];
        d_m = 50 + 2 * (m == 0 ? LAT0 : LAT1);
        if (abort_v[m]) begin
          act_m[m] = 1'b0;
        end else if (act_m[m]) begin
          if (start_v[m] && t_m < d_m) ovr_m[m] = 1'b1;
          if (t_m == d_m - 1) blk_m[m] = (blk_m[m] + 1) % (m == 0 ? (1 << W0) : (1 << W1));
          if (t_m == d_m) act_m[m] = 1'b0;
        end else if (start_v[m]) begin
          act_m[m] = 1'b1;
          s_m[m]   = cyc;
        end
        if (clr_v[m]) begin
          ovr_m[m] = 1'b0;
          blk_m[m] = 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp0 = expect_obs(LAT0, act_m[0], cyc - s_m[0]);
      exp1 = expect_obs(LAT1, act_m[1], cyc - s_m[1]);
      got0 = {busy0, done0, rd_en0, addr0, reg1en0, mux1_0, stb0, twr0, trd0, mux2_0, wren0, wrc0, rec0};
      got1 = {busy1, done1, rd_en1, addr1, reg1en1, mux1_1, stb1, twr1, trd1, mux2_1, wren1, wrc1, rec1};
      checks++;
      if (got0 !== exp0) begin
        errors++;
        $display("FAIL cyc %0d u4 outputs: got %h want %h", cyc, got0, exp0);
      end
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL cyc %0d u1 outputs: got %h want %h", cyc, got1, exp1);
      end
      checks++;
      if (32'(blk0) !== blk_m[0] || ovr0 !== ovr_m[0]) begin
        errors++;
        $display("FAIL cyc %0d u4 blk/ovr: got %0d/%0b want %0d/%0b", cyc, blk0, ovr0, blk_m[0], ovr_m[0]);
      end
      checks++;
      if (32'(blk1) !== blk_m[1] || ovr1 !== ovr_m[1]) begin
        errors++;
        $display("FAIL cyc %0d u1 blk/ovr: got %0d/%0b want %0d/%0b", cyc, blk1, ovr1, blk_m[1], ovr_m[1]);
      end
      checks++;
      if ((twr0 && trd0) || (twr1 && trd1)) begin
        errors++;
        $display("FAIL cyc %0d twr/trd overlap: got u4 %0b%0b u1 %0b%0b want no overlap", cyc, twr0, trd0, twr1, trd1);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
    else $display("check %s = %0d", name, got);
  endtask

  function automatic logic dut_done(input int m);
    return (m == 0) ? done0 : done1;
  endfunction

  task automatic pulse_start(input int m, output int s);
    start_v[m] = 1'b1;
    tick();
    start_v[m] = 1'b0;
    s = cyc - 1;
  endtask

  task automatic wait_done(input int m, input int limit);
    int n = 0;
    while (!dut_done(m) && n < limit) begin
      tick();
      n++;
    end
    if (!dut_done(m)) begin
      checks++;
      errors++;
      $display("FAIL u%0d done timeout: got none want pulse within %0d cycles", m, limit);
    end
  endtask

  task automatic run_b2b(input int m, input int n, input int spacing);
    int last = -1;
    int s;
    for (int k = 0; k < n; k++) begin
      pulse_start(m, s);
      wait_done(m, 100);
      if (last >= 0) chk($sformatf("u%0d b2b spacing", m), cyc - last, spacing);
      last = cyc;
      tick();
    end
  endtask

  initial begin
    int s;
    repeat (3) tick();
    chk("reset busy", busy0, 0);
    chk("reset blk_cnt", blk0, 0);
    chk("reset wren", wren1, 0);
    #2 rst = 1'b0;
    tick();

    // single block on both latencies
    start_v = 2'b11;
    tick();
    start_v = 2'b00;
    s = cyc - 1;
    chk("u4 first rd_addr", addr0, 0);
    chk("u4 first rd_en", rd_en0, 1);
    tick_to(s + 4);  chk("u1 first twr", twr1, 1);
    tick_to(s + 16); chk("u4 last rd_addr", addr0, 15);
    tick_to(s + 18); chk("u1 last twr", twr1, 1);
    tick_to(s + 21); chk("u4 last twr", twr0, 1);
    tick_to(s + 22); chk("u4 first trd", trd0, 1);
    tick_to(s + 26); chk("u4 first wren", wren0, 1); chk("u4 first wrc", wrc0, 0);
    tick_to(s + 52); chk("u1 done at S+52", done1, 1); chk("u1 blk_cnt", blk1, 1);
    tick_to(s + 57); chk("u4 last wrc", wrc0, 31); chk("u4 last rec_idx", rec0, 62); chk("u4 last mux2", mux2_0, 3);
    tick_to(s + 58); chk("u4 done at S+58", done0, 1); chk("u4 blk_cnt", blk0, 1);
    tick();          chk("u4 busy after done", busy0, 0);

    // start while busy, then clear coincident with done
    pulse_start(0, s);
    tick_to(s + 10);
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    chk("ovr set", ovr0, 1);
    wait_done(0, 100);
    chk("ovr run done offset", cyc - s, 58);
    chk("ovr run blk_cnt", blk0, 2);
    clr_v[0] = 1'b1; tick(); clr_v[0] = 1'b0;
    chk("clr ovr", ovr0, 0);
    chk("clr blk_cnt", blk0, 0);
    tick();

    // abort mid column pass, then a clean block
    pulse_start(0, s);
    tick_to(s + 30);
    abort_v[0] = 1'b1; tick(); abort_v[0] = 1'b0;
    chk("abort busy", busy0, 0);
    chk("abort wren", wren0, 0);
    tick(); tick();
    pulse_start(0, s);
    wait_done(0, 100);
    chk("post-abort done offset", cyc - s, 58);
    chk("post-abort blk_cnt", blk0, 1);
    tick();

    // asynchronous reset between edges
    pulse_start(0, s);
    tick_to(s + 40);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", busy0, 0);
    chk("async rst wren", wren0, 0);
    chk("async rst blk_cnt", blk0, 0);
    tick();
    #2 rst = 1'b0;
    tick();
    pulse_start(0, s);
    wait_done(0, 100);
    chk("recovery done offset", cyc - s, 58);
    chk("recovery blk_cnt", blk0, 1);
    tick();

    // back-to-back blocks; the narrow counter wraps
    fork
      run_b2b(0, 3, 59);
      run_b2b(1, 18, 53);
    join
    chk("u4 b2b blk_cnt", blk0, 4);
    chk("u1 wrapped blk_cnt", blk1, 2);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
